// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC frame scheduler:
//   NUM_CH            number of sample channels
//   CMD_WRITE_UPDATE  default command nibble (write-and-update)
//   state_t           scheduler FSM states
//   build_header()    frame header builder {cmd, 1'b0, ch, 1'b0}
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int NUM_CH = 4;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Header byte: command nibble, reserved zero, channel id, reserved zero.
    function automatic logic [7:0] build_header(input logic [3:0] cmd, input logic [1:0] ch);
        return {cmd, 1'b0, ch, 1'b0};
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. The search starts at the
// channel after `last` and grants the first requester found.
// Ports:
//   req    [3:0]  request vector, bit n = channel n
//   last   [1:0]  most recently granted channel
//   gnt    [3:0]  one-hot grant (all zero when no request)
//   gnt_id [1:0]  index of granted channel (0 when no request)
//   any           at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter4
    import dac_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       any
);

    logic [1:0] cand_s;

    // Rotating priority search; the 2-bit add wraps 3 -> 0 naturally.
    always_comb begin
        gnt    = 4'b0000;
        gnt_id = 2'd0;
        any    = 1'b0;
        cand_s = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s = last + 2'(i + 1);
            if (!any && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_id      = cand_s;
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/dac_frame_sched.sv
// -----------------------------------------------------------------------------
// dac_frame_sched
// Collects 16-bit samples from four channels using round-robin arbitration,
// wraps each in a 24-bit frame {header, sample} for a downstream serializer
// and enforces FRAME_GAP idle cycles after each accepted frame.
// Parameters:
//   FRAME_GAP  idle cycles after each frame handshake (0..255)
//   CMD        command nibble in every header
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                enable for new grants (does not abort a frame in flight)
//   ch_valid/ch_data  per-channel sample requests and data (ch n at [16n+:16])
//   ch_ready          one-hot accept strobe, combinational, only in IDLE
//   frame_data/valid  frame to serializer, held until frame_ready
//   frame_ready       serializer accept
//   busy              FSM not in IDLE
//   last_ch           channel of the most recently accepted sample
//   frame_count       frames handed to the serializer (wrapping)
// -----------------------------------------------------------------------------
module dac_frame_sched
    import dac_pkg::*;
#(
    parameter int unsigned FRAME_GAP = 32,
    parameter logic [3:0]  CMD       = CMD_WRITE_UPDATE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  ch_valid,
    input  logic [63:0] ch_data,
    output logic [3:0]  ch_ready,
    output logic [23:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy,
    output logic [1:0]  last_ch,
    output logic [15:0] frame_count
);

    localparam logic [7:0] GAP_LOAD = 8'(FRAME_GAP);

    state_t      state_r;
    logic [7:0]  gap_cnt_r;
    logic [23:0] frame_data_r;
    logic        frame_valid_r;
    logic        busy_r;
    logic [1:0]  last_ch_r;
    logic [15:0] frame_count_r;

    logic [3:0]  gnt_s;
    logic [1:0]  gnt_id_s;
    logic        any_s;
    logic [3:0]  ch_ready_s;
    logic [15:0] sample_s;
    logic        transfer_s;

    rr_arbiter4 u_arb (
        .req    (ch_valid),
        .last   (last_ch_r),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s),
        .any    (any_s)
    );

    // Accept strobe is only offered while idle and enabled, so requests are never latched.
    always_comb begin
        ch_ready_s = 4'b0000;
        if ((state_r == IDLE) && en && any_s) begin
            ch_ready_s = gnt_s;
        end else begin
            ch_ready_s = 4'b0000;
        end
    end

    // Select the granted channel's sample.
    always_comb begin
        sample_s = 16'h0000;
        case (gnt_id_s)
            2'd0:    sample_s = ch_data[15:0];
            2'd1:    sample_s = ch_data[31:16];
            2'd2:    sample_s = ch_data[47:32];
            2'd3:    sample_s = ch_data[63:48];
            default: sample_s = 16'h0000;
        endcase
    end

    assign transfer_s = |(ch_valid & ch_ready_s);

    // Scheduler FSM with registered frame outputs, gap counter and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            gap_cnt_r     <= 8'd0;
            frame_data_r  <= 24'h000000;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            last_ch_r     <= 2'd3;
            frame_count_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (transfer_s) begin
                        frame_data_r  <= {build_header(CMD, gnt_id_s), sample_s};
                        last_ch_r     <= gnt_id_s;
                        frame_valid_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= SEND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (frame_ready) begin
                        frame_valid_r <= 1'b0;
                        frame_count_r <= frame_count_r + 16'd1;
                        if (GAP_LOAD == 8'd0) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            gap_cnt_r <= GAP_LOAD;
                            state_r   <= GAP;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                GAP: begin
                    // Counter is loaded with FRAME_GAP on entry; leave on the last gap cycle.
                    if (gap_cnt_r <= 8'd1) begin
                        gap_cnt_r <= 8'd0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    gap_cnt_r     <= 8'd0;
                    frame_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign ch_ready    = ch_ready_s;
    assign frame_data  = frame_data_r;
    assign frame_valid = frame_valid_r;
    assign busy        = busy_r;
    assign last_ch     = last_ch_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_dac_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_sched
// Scoreboard bench: expected frames are queued when stimulus is issued and a
// monitor per instance pops and compares on every frame handshake. Instance
// "a" uses FRAME_GAP=3, instance "b" uses FRAME_GAP=0 for back-to-back frames
// and counter wrap.
// -----------------------------------------------------------------------------
module tb_dac_frame_sched;

    localparam logic [63:0] DATA = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, frame_ready, frame_valid, busy;
    logic [3:0]  ch_valid, ch_ready;
    logic [63:0] ch_data;
    logic [23:0] frame_data;
    logic [1:0]  last_ch;
    logic [15:0] frame_count;

    logic        rst_n_b, en_b, frame_ready_b, frame_valid_b, busy_b;
    logic [3:0]  ch_valid_b, ch_ready_b;
    logic [63:0] ch_data_b;
    logic [23:0] frame_data_b;
    logic [1:0]  last_ch_b;
    logic [15:0] frame_count_b;

    dac_frame_sched #(.FRAME_GAP(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .last_ch(last_ch), .frame_count(frame_count)
    );

    dac_frame_sched #(.FRAME_GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .ch_valid(ch_valid_b), .ch_data(ch_data_b),
        .ch_ready(ch_ready_b), .frame_data(frame_data_b), .frame_valid(frame_valid_b),
        .frame_ready(frame_ready_b), .busy(busy_b), .last_ch(last_ch_b), .frame_count(frame_count_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // Monitor for instance a: every handshake must match the next expected frame.
    always @(negedge clk) begin
        if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected_frame: got %h expected none", frame_data);
            end else begin
                chk("a_frame", {8'd0, frame_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (frame_valid_b === 1'b1 && frame_ready_b === 1'b1) begin
            if (exp_qb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected_frame: got %h expected none", frame_data_b);
            end else begin
                chk("b_frame", {8'd0, frame_data_b}, {8'd0, exp_qb.pop_front()});
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, t, last_t, bad;
        logic [3:0]  exp_oh;
        logic [15:0] exp_cnt;

        rst_n = 1'b0; en = 1'b0; ch_valid = 4'h0; ch_data = DATA; frame_ready = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b0; ch_valid_b = 4'h0; ch_data_b = DATA; frame_ready_b = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_data", {8'd0, frame_data}, 32'd0);
        chk("rst_ch_ready", {28'd0, ch_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_last_ch", {30'd0, last_ch}, 32'd3);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);

        // Single request on channel 2
        tick();
        rst_n = 1'b1; en = 1'b1; ch_valid = 4'b0100; ch_data[47:32] = 16'hA527; frame_ready = 1'b1;
        exp_q.push_back(24'h14A527);
        @(negedge clk);
        chk("single_ch_ready", {28'd0, ch_ready}, 32'h4);
        tick();
        ch_valid = 4'h0;
        @(negedge clk);
        chk("single_frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_no_ready", {28'd0, ch_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid_drop", {31'd0, frame_valid}, 32'd0);
        chk("single_count", {16'd0, frame_count}, 32'd1);
        chk("single_last_ch", {30'd0, last_ch}, 32'd2);
        ch_data = DATA;
        wait_idle("single_idle");

        // Round-robin with all channels requesting, FRAME_GAP=3
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ch_valid = 4'hF;
        exp_q.push_back(24'h101111);
        exp_q.push_back(24'h122222);
        exp_q.push_back(24'h143333);
        exp_q.push_back(24'h164444);
        exp_q.push_back(24'h101111);
        g = 0; t = 0; last_t = 0;
        while (g < 5 && t < 60) begin
            @(negedge clk);
            if (ch_ready !== 4'b0000) begin
                exp_oh = 4'(1 << (g % 4));
                chk("rr_grant", {28'd0, ch_ready}, {28'd0, exp_oh});
                if (g > 0) chk("rr_spacing", t - last_t, 32'd5);
                last_t = t;
                g++;
            end
            tick();
            t++;
        end
        if (g < 5) chk("rr_timeout", g, 32'd5);
        ch_valid = 4'h0;
        wait_idle("rr_idle");
        chk("rr_count", {16'd0, frame_count}, 32'd5);

        // Serializer stall for 10 cycles in SEND
        tick();
        frame_ready = 1'b0; ch_valid = 4'b0010; ch_data[31:16] = 16'hBEEF;
        exp_q.push_back(24'h12BEEF);
        @(negedge clk);
        chk("stall_grant", {28'd0, ch_ready}, 32'h2);
        tick();
        ch_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_data", {8'd0, frame_data}, 32'h0012BEEF);
            chk("stall_no_ready", {28'd0, ch_ready}, 32'd0);
            tick();
        end
        frame_ready = 1'b1; ch_valid = 4'h0;
        @(negedge clk);
        chk("stall_valid_c11", {31'd0, frame_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("stall_released", {31'd0, frame_valid}, 32'd0);
        chk("stall_count", {16'd0, frame_count}, 32'd6);
        ch_data = DATA;
        wait_idle("stall_idle");

        // Enable dropped one cycle after grant
        tick();
        en = 1'b1; ch_valid = 4'hF; frame_ready = 1'b1;
        exp_q.push_back(24'h143333);
        @(negedge clk);
        chk("en_grant", {28'd0, ch_ready}, 32'h4);
        tick();
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ch_ready !== 4'b0000) bad++;
            tick();
        end
        @(negedge clk);
        chk("en_off_no_grant", bad, 32'd0);
        chk("en_off_idle", {31'd0, busy}, 32'd0);
        chk("en_off_count", {16'd0, frame_count}, 32'd7);
        tick();
        en = 1'b1;
        exp_q.push_back(24'h164444);
        @(negedge clk);
        chk("en_on_grant", {28'd0, ch_ready}, 32'h8);
        tick();
        ch_valid = 4'h0;
        wait_idle("en_idle");
        chk("en_count", {16'd0, frame_count}, 32'd8);

        // Reset while a frame is pending
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; frame_ready = 1'b0; ch_valid = 4'b0010;
        @(negedge clk);
        chk("rstmid_grant", {28'd0, ch_ready}, 32'h2);
        tick();
        ch_valid = 4'h0;
        @(negedge clk);
        chk("rstmid_pending", {31'd0, frame_valid}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ch_valid = 4'hF; frame_ready = 1'b1;
        exp_q.push_back(24'h101111);
        @(negedge clk);
        chk("rstmid_valid", {31'd0, frame_valid}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_count", {16'd0, frame_count}, 32'd0);
        chk("rstmid_next_ch0", {28'd0, ch_ready}, 32'h1);
        tick();
        ch_valid = 4'h0;
        wait_idle("rstmid_idle");

        // FRAME_GAP=0: back-to-back frames and frame_count wrap
        tick();
        rst_n_b = 1'b1;
        force dut_b.frame_count_r = 16'hFFFD;
        @(negedge clk);
        release dut_b.frame_count_r;
        chk("b_preset", {16'd0, frame_count_b}, 32'h0000FFFD);
        tick();
        en_b = 1'b1; frame_ready_b = 1'b1; ch_valid_b = 4'hF;
        exp_qb.push_back(24'h101111);
        exp_qb.push_back(24'h122222);
        exp_qb.push_back(24'h143333);
        exp_qb.push_back(24'h164444);
        g = 0; t = 0; last_t = 0;
        while (g < 4 && t < 40) begin
            @(negedge clk);
            if (ch_ready_b !== 4'b0000) begin
                exp_oh = 4'(1 << g);
                exp_cnt = 16'hFFFD + 16'(g);
                chk("b_grant", {28'd0, ch_ready_b}, {28'd0, exp_oh});
                chk("b_count_step", {16'd0, frame_count_b}, {16'd0, exp_cnt});
                if (g > 0) chk("b_spacing", t - last_t, 32'd2);
                last_t = t;
                g++;
            end
            tick();
            t++;
        end
        if (g < 4) chk("b_timeout", g, 32'd4);
        ch_valid_b = 4'h0;
        repeat (3) tick();
        @(negedge clk);
        chk("b_count_final", {16'd0, frame_count_b}, 32'h0001);

        chk("a_queue_drained", exp_q.size(), 32'd0);
        chk("b_queue_drained", exp_qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
